// File: rtl/mem_1r1w_masked_32x64_ctrl_if.sv
`timescale 1ns/1ps
// Bus bundle between the memory controller, its requesters and the 1R1W macro.
// slave  : controller view.
// master : view of the agents around the controller (requesters and macro).
interface mem_1r1w_masked_32x64_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
);
  logic              w0_valid;
  logic              w0_ready;
  logic [ADDR_W-1:0] w0_addr;
  logic [DATA_W-1:0] w0_data;
  logic [MASK_W-1:0] w0_mask;

  logic              w1_valid;
  logic              w1_ready;
  logic [ADDR_W-1:0] w1_addr;
  logic [DATA_W-1:0] w1_data;
  logic [MASK_W-1:0] w1_mask;

  logic              r_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  logic [ADDR_W-1:0] mem_R0_addr;
  logic              mem_R0_en;
  logic [DATA_W-1:0] mem_R0_data;
  logic [ADDR_W-1:0] mem_W0_addr;
  logic              mem_W0_en;
  logic [DATA_W-1:0] mem_W0_data;
  logic [MASK_W-1:0] mem_W0_mask;

  modport slave (
    input  w0_valid, w0_addr, w0_data, w0_mask,
    input  w1_valid, w1_addr, w1_data, w1_mask,
    input  r_valid, r_addr, mem_R0_data,
    output w0_ready, w1_ready, r_ready, rsp_valid, rsp_data,
    output mem_R0_addr, mem_R0_en,
    output mem_W0_addr, mem_W0_en, mem_W0_data, mem_W0_mask
  );

  modport master (
    output w0_valid, w0_addr, w0_data, w0_mask,
    output w1_valid, w1_addr, w1_data, w1_mask,
    output r_valid, r_addr, mem_R0_data,
    input  w0_ready, w1_ready, r_ready, rsp_valid, rsp_data,
    input  mem_R0_addr, mem_R0_en,
    input  mem_W0_addr, mem_W0_en, mem_W0_data, mem_W0_mask
  );
endinterface

// File: rtl/mem_1r1w_masked_32x64_ctrl.sv
`timescale 1ns/1ps
// Front-end for one mem_1r1w_masked_32x64 macro: round-robin sharing of the
// write port between two byte-masked requesters, 1-cycle reads with
// same-cycle write forwarding, and a full-array zero-fill after reset or
// on clr_req.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zero-fill, one entry per cycle from cnt_q=0 to DEPTH-1; busy
// ST_RUN   | normal operation: write arbitration and reads accepted
module mem_1r1w_masked_32x64_ctrl #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic clr_req_i,
  output logic busy_o,
  mem_1r1w_masked_32x64_ctrl_if.slave bus
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rr_q, rr_d;        // 0: w0 wins a tie, 1: w1 wins a tie

  logic              rsp_valid_q;
  logic              hit_q, hit_d;
  logic [DATA_W-1:0] fwd_data_q;
  logic [MASK_W-1:0] fwd_mask_q;

  logic              gnt0, gnt1;
  logic              wr_en, rd_en, rd_rdy;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MASK_W-1:0] wr_mask;
  logic [DATA_W-1:0] rsp_data_c;

  // State register, fill counter and round-robin pointer.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  // Next state: the fill ends after the write at DEPTH-1; clr_req restarts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (clr_req_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: fill writes in CLEAR; write grant, pointer update and read accept in RUN.
  always_comb begin
    busy_o  = (state_q == ST_CLEAR);
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_mask = '0;
    rd_rdy  = 1'b0;
    rd_en   = 1'b0;
    rr_d    = rr_q;
    case (state_q)
      ST_CLEAR: begin
        // Held off while reset is asserted so the macro sees no write then.
        wr_en   = reset_n_i;
        wr_addr = cnt_q;
        wr_data = '0;
        wr_mask = '1;
      end
      ST_RUN: begin
        gnt0  = bus.w0_valid & (~bus.w1_valid | ~rr_q);
        gnt1  = bus.w1_valid & ~gnt0;
        wr_en = gnt0 | gnt1;
        if (gnt1) begin
          wr_addr = bus.w1_addr;
          wr_data = bus.w1_data;
          wr_mask = bus.w1_mask;
        end else begin
          wr_addr = bus.w0_addr;
          wr_data = bus.w0_data;
          wr_mask = bus.w0_mask;
        end
        if (gnt0) rr_d = 1'b1;
        else if (gnt1) rr_d = 1'b0;
        rd_rdy = 1'b1;
        rd_en  = bus.r_valid;
      end
      default: ;
    endcase
  end

  // A read colliding with the granted write gets the write bytes forwarded.
  assign hit_d = rd_en & wr_en & (bus.r_addr == wr_addr);

  // Response pipeline: one-cycle valid plus the captured collision write.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rsp_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      fwd_data_q  <= '0;
      fwd_mask_q  <= '0;
    end else begin
      rsp_valid_q <= rd_en;
      hit_q       <= hit_d;
      fwd_data_q  <= wr_data;
      fwd_mask_q  <= wr_mask;
    end
  end

  // Byte merge: forwarded write bytes override the macro's undefined collision data.
  always_comb begin
    rsp_data_c = bus.mem_R0_data;
    for (int i = 0; i < MASK_W; i++) begin
      if (hit_q && fwd_mask_q[i]) rsp_data_c[8*i +: 8] = fwd_data_q[8*i +: 8];
    end
  end

  assign bus.w0_ready    = gnt0;
  assign bus.w1_ready    = gnt1;
  assign bus.r_ready     = rd_rdy;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_c;
  assign bus.mem_R0_en   = rd_en;
  assign bus.mem_R0_addr = bus.r_addr;
  assign bus.mem_W0_en   = wr_en;
  assign bus.mem_W0_addr = wr_addr;
  assign bus.mem_W0_data = wr_data;
  assign bus.mem_W0_mask = wr_mask;

endmodule

// File: tb/tb_mem_1r1w_masked_32x64_ctrl.sv
`timescale 1ns/1ps
// Bench for mem_1r1w_masked_32x64_ctrl: behavioural macro plus a reference
// model of expected memory contents, grants and responses.
module tb_mem_1r1w_masked_32x64_ctrl;
  localparam int DEPTH = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic clr_req = 1'b0;
  logic busy;

  mem_1r1w_masked_32x64_ctrl_if bus ();

  mem_1r1w_masked_32x64_ctrl dut (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .clr_req_i (clr_req),
    .busy_o    (busy),
    .bus       (bus.slave)
  );

  always #5 clock = ~clock;

  // Macro stand-in: read returns the pre-write contents on a collision.
  logic [63:0] macro_mem [DEPTH];
  always @(posedge clock) begin
    if (bus.mem_R0_en) bus.mem_R0_data <= macro_mem[bus.mem_R0_addr];
    if (bus.mem_W0_en)
      for (int i = 0; i < 8; i++)
        if (bus.mem_W0_mask[i]) macro_mem[bus.mem_W0_addr][8*i +: 8] <= bus.mem_W0_data[8*i +: 8];
  end

  // Reference model state.
  logic [63:0] ref_mem [DEPTH];
  bit          m_clear;
  int          m_idx;
  bit          m_ptr;       // requester that wins a tie
  bit          m_pend;
  logic [63:0] m_pend_data;

  int          n_cmp = 0;
  int          n_err = 0;
  int          busy_cycles;
  logic [63:0] last_rsp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model, return at posedge+1.
  task automatic cycle(input bit v0, input logic [4:0] a0, input logic [63:0] d0, input logic [7:0] m0,
                       input bit v1, input logic [4:0] a1, input logic [63:0] d1, input logic [7:0] m1,
                       input bit vr, input logic [4:0] ar, input bit clr);
    bit          e_g0, e_g1, e_wen, e_rd;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    logic [7:0]  e_wm;
    bus.w0_valid = v0; bus.w0_addr = a0; bus.w0_data = d0; bus.w0_mask = m0;
    bus.w1_valid = v1; bus.w1_addr = a1; bus.w1_data = d1; bus.w1_mask = m1;
    bus.r_valid  = vr; bus.r_addr  = ar;
    clr_req      = clr;
    @(negedge clock);
    if (m_clear) begin
      e_g0 = 0; e_g1 = 0; e_wen = 1; e_wa = 5'(m_idx); e_wd = '0; e_wm = 8'hFF; e_rd = 0;
    end else begin
      if (v0 && v1) begin
        e_g0 = (m_ptr == 1'b0);
        e_g1 = (m_ptr == 1'b1);
      end else begin
        e_g0 = v0;
        e_g1 = v1;
      end
      e_wen = e_g0 | e_g1;
      e_wa  = e_g0 ? a0 : a1;
      e_wd  = e_g0 ? d0 : d1;
      e_wm  = e_g0 ? m0 : m1;
      e_rd  = vr;
    end
    chk("busy", busy, m_clear);
    chk("w0_ready", bus.w0_ready, e_g0);
    chk("w1_ready", bus.w1_ready, e_g1);
    chk("r_ready", bus.r_ready, !m_clear);
    chk("W0_en", bus.mem_W0_en, e_wen);
    if (e_wen) begin
      chk("W0_addr", bus.mem_W0_addr, e_wa);
      chk("W0_data", bus.mem_W0_data, e_wd);
      chk("W0_mask", bus.mem_W0_mask, e_wm);
    end
    chk("R0_en", bus.mem_R0_en, e_rd);
    if (e_rd) chk("R0_addr", bus.mem_R0_addr, ar);
    chk("rsp_valid", bus.rsp_valid, m_pend);
    if (m_pend) chk("rsp_data", bus.rsp_data, m_pend_data);
    if (busy === 1'b1) busy_cycles++;
    if (bus.rsp_valid === 1'b1) last_rsp = bus.rsp_data;
    // Model: write lands first, then the read sees the post-write value.
    if (e_wen)
      for (int i = 0; i < 8; i++)
        if (e_wm[i]) ref_mem[e_wa][8*i +: 8] = e_wd[8*i +: 8];
    m_pend = e_rd;
    if (e_rd) m_pend_data = ref_mem[ar];
    if (m_clear) begin
      m_idx++;
      if (m_idx == DEPTH) m_clear = 0;
    end else begin
      if (e_g0) m_ptr = 1'b1;
      else if (e_g1) m_ptr = 1'b0;
      if (clr) begin
        m_clear = 1;
        m_idx   = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset entered mid-cycle, released at posedge+1.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_W0_en", bus.mem_W0_en, 1'b0);
    chk("rst_R0_en", bus.mem_R0_en, 1'b0);
    chk("rst_w0_ready", bus.w0_ready, 1'b0);
    chk("rst_w1_ready", bus.w1_ready, 1'b0);
    chk("rst_r_ready", bus.r_ready, 1'b0);
    m_clear = 1; m_idx = 0; m_ptr = 0; m_pend = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    bus.w0_valid = 0; bus.w0_addr = 0; bus.w0_data = 0; bus.w0_mask = 0;
    bus.w1_valid = 0; bus.w1_addr = 0; bus.w1_data = 0; bus.w1_mask = 0;
    bus.r_valid  = 0; bus.r_addr  = 0;
    @(posedge clock);
    #1;

    // Reset, then a full fill with every requester valid.
    do_reset();
    busy_cycles = 0;
    for (int k = 0; k < DEPTH; k++)
      cycle(1, 5'd1, 64'h1, 8'hFF, 1, 5'd2, 64'h2, 8'hFF, 1, 5'd3, 1'b1);
    chk("fill_busy_cycles", busy_cycles, DEPTH);
    cycle(1, 5'd1, 64'h1, 8'hFF, 1, 5'd2, 64'h2, 8'hFF, 0, 0, 0);   // first grant: w0
    cycle(0, 0, 0, 0, 1, 5'd2, 64'h2, 8'hFF, 0, 0, 0);               // pointer back to w0

    // Alternating grants with both requesters held.
    for (int k = 0; k < 4; k++)
      cycle(1, 5'd3, {$urandom, $urandom}, 8'hFF, 1, 5'd7, {$urandom, $urandom}, 8'hFF, 0, 0, 0);

    // Plain write then read.
    cycle(0, 0, 0, 0, 1, 5'd5, 64'h1122334455667788, 8'hFF, 0, 0, 0);
    idle();
    last_rsp = '1;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0);
    idle();
    chk("read_addr5", last_rsp, 64'h1122334455667788);

    // Same-cycle collision with a one-byte mask.
    cycle(1, 5'd9, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    last_rsp = '1;
    cycle(1, 5'd9, 64'h00000000000000FF, 8'h01, 0, 0, 0, 0, 1, 5'd9, 0);
    idle();
    chk("collision_addr9", last_rsp, 64'hAAAAAAAAAAAAAAFF);

    // Zero mask still takes the port.
    cycle(1, 5'd12, 64'hDEADBEEFDEADBEEF, 8'h00, 0, 0, 0, 0, 1, 5'd12, 0);
    idle();

    // clr_req with a concurrent write; the fill then wipes it.
    cycle(1, 5'd2, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 0, 0, 0, 0, 1);
    busy_cycles = 0;
    for (int k = 0; k < DEPTH; k++) idle();
    chk("clr_busy_cycles", busy_cycles, DEPTH);
    last_rsp = '1;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd2, 0);
    idle();
    chk("read_after_clr", last_rsp, 64'h0);

    // Reset with a response pending.
    cycle(1, 5'd4, 64'h55, 8'hFF, 0, 0, 0, 0, 1, 5'd4, 0);
    do_reset();
    for (int k = 0; k < DEPTH; k++) idle();

    // Reset in the middle of a fill at counter 17.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 17; k++) idle();
    do_reset();
    busy_cycles = 0;
    for (int k = 0; k < DEPTH; k++)
      cycle(1, 5'd8, 64'h8, 8'hFF, 1, 5'd9, 64'h9, 8'hFF, 1, 5'd10, 1'b1);
    chk("refill_busy_cycles", busy_cycles, DEPTH);

    // Randomized traffic over a small address window to provoke collisions.
    for (int k = 0; k < 600; k++) begin
      bit          rv0, rv1, rvr, rclr;
      logic [4:0]  ra0, ra1, rar;
      logic [63:0] rd0, rd1;
      logic [7:0]  rm0, rm1;
      rv0  = ($urandom_range(0, 3) != 0);
      rv1  = ($urandom_range(0, 3) != 0);
      rvr  = ($urandom_range(0, 2) != 0);
      rclr = ($urandom_range(0, 63) == 0);
      ra0  = 5'($urandom_range(0, 7));
      ra1  = 5'($urandom_range(0, 7));
      rar  = 5'($urandom_range(0, 7));
      rd0  = {$urandom, $urandom};
      rd1  = {$urandom, $urandom};
      rm0  = 8'($urandom);
      rm1  = 8'($urandom);
      cycle(rv0, ra0, rd0, rm0, rv1, ra1, rd1, rm1, rvr, rar, rclr);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_1r1w_masked_32x64_ctrl.md
Name: mem_1r1w_masked_32x64_ctrl

Overview:
- Controller that sits in front of one mem_1r1w_masked_32x64 instance and shares its single write port between two byte-masked write requesters using round-robin arbitration.
- Serves one read requester with fixed 1-cycle latency and forwards same-address same-cycle write bytes into the read response, because the macro's collision behaviour is undefined.
- Zero-fills the whole array after reset and on request.

Parameters:
- DEPTH, 32, number of memory entries.
- ADDR_W, 5, address width; equals log2(DEPTH).
- DATA_W, 64, data width.
- MASK_W, 8, mask width; one bit per 8-bit byte.

Ports:
- clock  input  1  single clock; also drives the memory R0_clk and W0_clk.
- reset_n  input  1  asynchronous, active-low reset.
- clr_req  input  1  pulse: start a zero-fill of the whole array.
- busy  output  1  high while a zero-fill is in progress.
- w0_valid, w1_valid  input  1  write request valid, one per requester.
- w0_ready, w1_ready  output  1  write request accepted this cycle.
- w0_addr, w1_addr  input  ADDR_W  write address.
- w0_data, w1_data  input  DATA_W  write data.
- w0_mask, w1_mask  input  MASK_W  byte enables; bit i covers data[8i+7:8i].
- r_valid  input  1  read request valid.
- r_ready  output  1  read request accepted this cycle.
- r_addr  input  ADDR_W  read address.
- rsp_valid  output  1  read response valid.
- rsp_data  output  DATA_W  read response data.
- mem_R0_addr  output  ADDR_W  to memory.
- mem_R0_en  output  1  to memory.
- mem_R0_data  input  DATA_W  from memory; valid the cycle after mem_R0_en.
- mem_W0_addr  output  ADDR_W  to memory.
- mem_W0_en  output  1  to memory.
- mem_W0_data  output  DATA_W  to memory.
- mem_W0_mask  output  MASK_W  to memory.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State CLEAR, clear counter 0, busy 1.
  - rsp_valid 0.
  - Round-robin pointer favours w0.
  - All ready outputs 0; mem_R0_en and mem_W0_en 0.
- FSM state CLEAR:
  - Each cycle: mem_W0_en=1, mem_W0_addr=counter, mem_W0_data=0, mem_W0_mask=all ones; counter increments.
  - The write at counter=DEPTH-1 is the last one; the next state is RUN and busy drops.
  - The fill takes exactly DEPTH cycles.
  - All ready outputs stay 0. r_valid and w*_valid are ignored, not queued.
  - clr_req during CLEAR is ignored.
- FSM state RUN:
  - clr_req=1 moves to CLEAR with counter 0 on the next edge.
  - In the cycle clr_req is sampled, the write and read grants still proceed as normal.
- Write arbitration (RUN only, combinational grant):
  - Only one valid: that requester is granted.
  - Both valid: the requester named by the pointer is granted.
  - After any grant, the pointer moves to the other requester. With no grant the pointer holds.
  - Granted requester: ready=1; mem_W0_en=1, and its addr/data/mask drive mem_W0_* in the same cycle.
  - A mask of all zeros is still granted and still drives mem_W0_en.
- Read (RUN only):
  - r_ready = 1 in RUN; mem_R0_en = r_valid & r_ready; mem_R0_addr = r_addr.
  - rsp_valid is asserted exactly 1 cycle after acceptance, for 1 cycle. There is no backpressure.
- Collision forwarding:
  - Applies when a read and a granted write hit the same address in the same cycle.
  - Register hit=1 plus the write's data and mask.
  - Next cycle, per byte i: rsp_data byte i = registered write byte if mask[i]=1, else mem_R0_data byte i.
  - With hit=0, rsp_data = mem_R0_data.
  - The read returns the post-write value (write-first).
- Reads in CLEAR are not accepted; no response is produced.
- Reset mid-CLEAR or mid-RUN restarts the full zero-fill.
- A pending response is dropped on reset (rsp_valid forced to 0).

Test Plan:
- Release reset; hold w0/w1/r valid -> busy=1 for 32 cycles and mem_W0 writes addresses 0..31 with data 0, mask 0xFF; all ready=0; busy falls; the first grant goes to w0.
- RUN, w0_valid and w1_valid both held for 4 cycles, addr 3 and 7 -> grants alternate w0,w1,w0,w1; mem_W0_addr sequence 3,7,3,7.
- Write w1 addr 5, data 0x1122334455667788, mask 0xFF; later read addr 5 -> rsp_valid 1 cycle after r_ready, rsp_data=0x1122334455667788.
- Memory addr 9 holds 0xAAAAAAAAAAAAAAAA; same cycle, read 9 and write 9 with data 0x00000000000000FF, mask 0x01 -> rsp_data=0xAAAAAAAAAAAAAAFF.
- clr_req in RUN with a concurrent write to addr 2 -> that write is granted; the following 32 cycles zero-fill; a read of addr 2 afterwards returns 0.
- Assert reset_n low during CLEAR at counter=17, with rsp_valid pending in RUN beforehand -> outputs reset immediately; the fill restarts at address 0 and takes the full 32 cycles.
